accu_feeder: RTL and testbench

Upstream stage for `accu`. Accepts 32-bit words over a valid/ready handshake and buffers them in a small word FIFO. Serializes each word into four consecutive bytes on `data_out`/`valid_out`, which drive `accu`'s `data_in`/`valid_in` directly. Every group of four bytes it emits is exactly one `accu` accumulation group, and words are sent back-to-back with no idle cycles.

---
 rtl/accu_pkg.sv | 17 +
 rtl/accu_word_fifo.sv | 56 +++++
 rtl/accu_feeder.sv | 118 +++++++++++
 tb/tb_accu_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// Shared definitions for the accu datapath and its upstream word feeder.
package accu_pkg;

  localparam int unsigned ACCU_BYTES  = 4;
  localparam int unsigned ACCU_IN_W   = 8;
  localparam int unsigned ACCU_OUT_W  = 10;
  localparam int unsigned ACCU_WORD_W = ACCU_BYTES * ACCU_IN_W;
  localparam int unsigned ACCU_IDX_W  = $clog2(ACCU_BYTES);

  localparam logic [ACCU_IDX_W-1:0] ACCU_LAST_IDX = ACCU_IDX_W'(ACCU_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/accu_word_fifo.sv
// Synchronous circular-buffer FIFO with occupancy counter; head word is visible
// on o_rdata whenever the FIFO is non-empty.
module accu_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset; the counter and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/accu_feeder.sv
// Buffers 32-bit words and serializes each into four back-to-back bytes
// (MSB first) so every emitted 4-byte run is one accu accumulation group.
module accu_feeder
  import accu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACCU_WORD_W-1:0]   word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  output logic [ACCU_IN_W-1:0]     data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int unsigned REM_W = ACCU_WORD_W - ACCU_IN_W;

  feeder_state_t           r_state;
  feeder_state_t           w_state_nxt;
  logic [ACCU_IDX_W-1:0]   r_idx;
  logic [ACCU_IDX_W-1:0]   w_idx_nxt;
  logic [ACCU_WORD_W-1:0]  r_shift;
  logic [ACCU_WORD_W-1:0]  w_shift_nxt;
  logic [ACCU_IN_W-1:0]    r_data;
  logic [ACCU_IN_W-1:0]    w_data_nxt;
  logic                    r_valid;
  logic                    w_valid_nxt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [ACCU_WORD_W-1:0]  w_head;

  assign word_ready = !w_full;
  assign w_push     = word_valid && !w_full;
  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign busy       = (r_state == SEND) || !w_empty;

  accu_word_fifo #(
    .DEPTH (DEPTH),
    .W     (ACCU_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (word_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // A load puts byte 0 straight onto data_out; r_shift keeps the remaining bytes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_pop       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        w_pop       = !w_empty;
      end
      SEND: begin
        if (r_idx == ACCU_LAST_IDX) begin
          w_pop = !w_empty;
          if (w_empty) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end
        end else begin
          w_data_nxt  = r_shift[ACCU_WORD_W-1 -: ACCU_IN_W];
          w_shift_nxt = {r_shift[REM_W-1:0], {ACCU_IN_W{1'b0}}};
          w_idx_nxt   = r_idx + 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    if (w_pop) begin
      w_state_nxt = SEND;
      w_idx_nxt   = '0;
      w_data_nxt  = w_head[ACCU_WORD_W-1 -: ACCU_IN_W];
      w_shift_nxt = {w_head[REM_W-1:0], {ACCU_IN_W{1'b0}}};
      w_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_accu_feeder.sv
// Directed self-checking bench for accu_feeder with DEPTH = 4.
module tb_accu_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [2:0]  fifo_level;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  accu_feeder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    word_in    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    word_in    = '0;
    #1;
    if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", word_ready); end
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_tests++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_tests++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++;
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [9:0]  sum;
    w   = 32'h302BDA11;
    sum = '0;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      word_valid = (e == 3);
      word_in    = w;
      tick();
      word_valid = 1'b0;
      if (e <= 3) begin
        n_tests++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid e%0d: got %b expected 0", e, valid_out); end
      end
      if (e == 3) begin
        chk("single_level_after_push", 32'(fifo_level), 32'd1);
        chk("single_busy_after_push", 32'(busy), 32'd1);
      end
      if (e >= 4 && e <= 7) begin
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== w[31-8*(e-4) -: 8]) begin
          n_fail++;
          $display("FAIL single_byte%0d: got v=%b d=%h expected v=1 d=%h", e-4, valid_out, data_out, w[31-8*(e-4) -: 8]);
        end
        sum += {2'b00, data_out};
      end
      if (e == 8) begin
        chk("single_valid_fall", 32'(valid_out), 32'd0);
        chk("single_busy_fall", 32'(busy), 32'd0);
        chk("single_data_hold", 32'(data_out), 32'h11);
      end
    end
    chk("single_accu_sum", 32'(sum), 32'h146);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ws;
    logic [9:0]  sum;
    ws  = {32'h302BDA11, 32'h9673D58C};
    sum = '0;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      word_valid = (e <= 2);
      word_in    = (e == 1) ? ws[63:32] : ws[31:0];
      tick();
      word_valid = 1'b0;
      if (e >= 2 && e <= 9) begin
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== ws[63-8*(e-2) -: 8]) begin
          n_fail++;
          $display("FAIL b2b_byte%0d: got v=%b d=%h expected v=1 d=%h", e-2, valid_out, data_out, ws[63-8*(e-2) -: 8]);
        end
        if (e >= 6) sum += {2'b00, data_out};
      end
      if (e == 10) chk("b2b_valid_fall", 32'(valid_out), 32'd0);
    end
    chk("b2b_second_sum", 32'(sum), 32'h26A);
  endtask

  task automatic test_backpressure();
    int          exp_lvl [6] = '{1, 1, 2, 3, 4, 3};
    bit          exp_rdy [6] = '{1, 1, 1, 1, 0, 1};
    logic [31:0] exp_q [$];
    logic [31:0] cur;
    int          accepted;
    int          nbytes;
    bit          acc;
    accepted = 0;
    nbytes   = 0;
    do_reset();
    word_valid = 1'b1;
    word_in    = 32'hC0DE0000;
    for (int e = 1; e <= 22; e++) begin
      acc = word_valid && word_ready;
      tick();
      if (acc) begin
        exp_q.push_back(word_in);
        accepted++;
        word_in = 32'hC0DE0000 + 32'(accepted);
      end
      if (e == 6) word_valid = 1'b0;
      if (e <= 6) begin
        n_tests++;
        if (word_ready !== exp_rdy[e-1] || fifo_level !== 3'(exp_lvl[e-1])) begin
          n_fail++;
          $display("FAIL bp_edge%0d: got rdy=%b lvl=%0d expected rdy=%b lvl=%0d",
                   e, word_ready, fifo_level, exp_rdy[e-1], exp_lvl[e-1]);
        end
      end
      if (e >= 2 && e <= 21) begin
        cur = exp_q[(e-2)/4];
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== cur[31-8*((e-2)%4) -: 8]) begin
          n_fail++;
          $display("FAIL bp_byte%0d: got v=%b d=%h expected v=1 d=%h", e-2, valid_out, data_out, cur[31-8*((e-2)%4) -: 8]);
        end
      end
      if (valid_out) nbytes++;
      if (e == 22) chk("bp_valid_fall", 32'(valid_out), 32'd0);
    end
    chk("bp_accepted", 32'(accepted), 32'd5);
    chk("bp_byte_count", 32'(nbytes), 32'd20);
  endtask

  task automatic test_simul_push_pop();
    logic [95:0] ws;
    ws = {32'h11223344, 32'h55667788, 32'h99AABBCC};
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      word_valid = (e == 1) || (e == 3) || (e == 6);
      word_in    = (e == 1) ? ws[95:64] : (e == 3) ? ws[63:32] : ws[31:0];
      tick();
      word_valid = 1'b0;
      if (e == 5) chk("simul_level_before", 32'(fifo_level), 32'd1);
      if (e == 6) chk("simul_level_after", 32'(fifo_level), 32'd1);
      if (e >= 2 && e <= 13) begin
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== ws[95-8*(e-2) -: 8]) begin
          n_fail++;
          $display("FAIL simul_byte%0d: got v=%b d=%h expected v=1 d=%h", e-2, valid_out, data_out, ws[95-8*(e-2) -: 8]);
        end
      end
      if (e == 14) chk("simul_valid_fall", 32'(valid_out), 32'd0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] y;
    y = 32'h95F43DA2;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      word_valid = (e <= 2);
      word_in    = (e == 1) ? 32'h4ECF8D9F : 32'h12345678;
      tick();
      word_valid = 1'b0;
    end
    chk("rstmid_byte1_seen", 32'(data_out), 32'hCF);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(valid_out), 32'd0);
    chk("rstmid_data", 32'(data_out), 32'h00);
    chk("rstmid_level", 32'(fifo_level), 32'd0);
    chk("rstmid_ready", 32'(word_ready), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      word_valid = (e == 1);
      word_in    = y;
      tick();
      word_valid = 1'b0;
      if (e == 1) chk("rstmid_no_stale", 32'(valid_out), 32'd0);
      if (e >= 2 && e <= 5) begin
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== y[31-8*(e-2) -: 8]) begin
          n_fail++;
          $display("FAIL rstmid_byte%0d: got v=%b d=%h expected v=1 d=%h", e-2, valid_out, data_out, y[31-8*(e-2) -: 8]);
        end
      end
      if (e == 6) chk("rstmid_valid_fall", 32'(valid_out), 32'd0);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0]  byte_q [$];
    logic [9:0]  sum_q [$];
    logic [31:0] cur;
    logic [9:0]  s;
    logic [9:0]  acc_sum;
    logic [7:0]  eb;
    int          pushed;
    int          seen;
    int          grp;
    int          cyc;
    bit          acc;
    pushed  = 0;
    seen    = 0;
    grp     = 0;
    cyc     = 0;
    acc_sum = '0;
    cur     = $urandom;
    do_reset();
    while ((pushed < 40 || seen < 160) && cyc < 3000) begin
      word_valid = (pushed < 40) && ($urandom_range(0, 3) != 0);
      word_in    = cur;
      acc        = word_valid && word_ready;
      tick();
      cyc++;
      if (acc) begin
        s = '0;
        for (int i = 0; i < 4; i++) begin
          byte_q.push_back(cur[31-8*i -: 8]);
          s += {2'b00, cur[31-8*i -: 8]};
        end
        sum_q.push_back(s);
        pushed++;
        cur = $urandom;
      end
      if (valid_out) begin
        n_tests++;
        if (byte_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_byte: got %h expected none", data_out);
        end else begin
          eb = byte_q.pop_front();
          if (data_out !== eb) begin
            n_fail++;
            $display("FAIL rand_byte%0d: got %h expected %h", seen, data_out, eb);
          end
        end
        seen++;
        acc_sum += {2'b00, data_out};
        grp++;
        if (grp == 4) begin
          s = (sum_q.size() != 0) ? sum_q.pop_front() : 10'h3FF;
          n_tests++;
          if (acc_sum !== s) begin
            n_fail++;
            $display("FAIL rand_accu_sum%0d: got %h expected %h", seen/4 - 1, acc_sum, s);
          end
          grp     = 0;
          acc_sum = '0;
        end
      end
    end
    word_valid = 1'b0;
    chk("rand_words_pushed", 32'(pushed), 32'd40);
    chk("rand_bytes_seen", 32'(seen), 32'd160);
    tick();
    chk("rand_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_word();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
